ldtu_lane_distributor: RTL

//  Parametrised successor of the LiTE-DTU output stage: drains the 32-bit output FIFO and serves NLANES serializer lanes.

---
 rtl/ldtu_lane_distributor.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ldtu_lane_distributor.sv
// Per-frame lane filler: pops the FWFT output FIFO round-robin into NLANES lanes, or emits ATU/IDLE/SYNC words.
// Output latency is one frame. A FIFO underflow fills the lane with IDLE_WORD. There is no stall path.
module ldtu_lane_distributor #(
  parameter int               NBITS        = 32,
  parameter int               NLANES       = 4,
  parameter int               WORD_CYCLES  = 8,
  parameter int               CNT_BITS     = 3,
  parameter int               ALIGN_FRAMES = 4,
  parameter logic [NBITS-1:0] IDLE_WORD    = 32'hEAAAAAAA,
  parameter logic [NBITS-1:0] SYNC_WORD    = 32'h5A5A5A5A
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CALIBRATION_BUSY,
  input  logic                    TEST_ENABLE,
  input  logic                    Orbit,
  input  logic                    fifo_empty,
  input  logic [NBITS-1:0]        fifo_data,
  output logic                    fifo_rd,
  input  logic [NLANES*NBITS-1:0] DATA32_ATU,
  output logic [NLANES*NBITS-1:0] DATA32_out,
  output logic                    load_strobe,
  output logic [1:0]              mode,
  output logic [15:0]             idle_cnt
);

  localparam int                  AW   = $clog2(ALIGN_FRAMES + 1);
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(WORD_CYCLES - 1);
  localparam logic [CNT_BITS:0]   NL   = (CNT_BITS + 1)'(NLANES);

  typedef enum logic [1:0] {
    MODE_DATA  = 2'b00,
    MODE_TEST  = 2'b01,
    MODE_CALIB = 2'b10,
    MODE_ALIGN = 2'b11
  } mode_t;

  mode_t                mode_q, mode_nxt;
  logic [CNT_BITS-1:0]  cnt;
  logic [AW-1:0]        align_cnt;
  logic                 orbit_pend;
  logic                 sync_frame;
  logic [NBITS-1:0]     staging [NLANES];
  logic [NLANES*NBITS-1:0] frame_result;
  logic                 boundary, in_fill, data_fill;
  logic [NBITS-1:0]     lane_word;

  assign boundary  = (cnt == LAST);
  assign in_fill   = ({1'b0, cnt} < NL);
  assign data_fill = (mode_q == MODE_DATA) && !sync_frame && in_fill;
  assign fifo_rd   = !RST && data_fill && !fifo_empty;
  assign lane_word = fifo_rd ? fifo_data : IDLE_WORD;
  assign mode      = mode_q;

  always_ff @(posedge CLK) begin
    if (RST) mode_q <= MODE_ALIGN;
    else     mode_q <= mode_nxt;
  end

  // Mode only moves at a frame boundary, so mid-frame input changes never split a frame.
  always_comb begin
    mode_nxt = mode_q;
    if (boundary) begin
      if (mode_q == MODE_ALIGN && align_cnt < AW'(ALIGN_FRAMES - 1)) mode_nxt = MODE_ALIGN;
      else if (CALIBRATION_BUSY)                                     mode_nxt = MODE_CALIB;
      else if (TEST_ENABLE)                                          mode_nxt = MODE_TEST;
      else                                                           mode_nxt = MODE_DATA;
    end
  end

  // The lane being filled on the boundary cycle bypasses staging so WORD_CYCLES == NLANES still works.
  always_comb begin
    frame_result = '0;
    case (mode_q)
      MODE_ALIGN: frame_result = {NLANES{SYNC_WORD}};
      MODE_TEST:  frame_result = DATA32_ATU;
      MODE_CALIB: frame_result = {NLANES{IDLE_WORD}};
      default: begin
        if (sync_frame) begin
          frame_result = {NLANES{SYNC_WORD}};
        end else begin
          for (int k = 0; k < NLANES; k++)
            frame_result[k*NBITS +: NBITS] =
              (in_fill && cnt == CNT_BITS'(k)) ? lane_word : staging[k];
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt         <= '0;
      align_cnt   <= '0;
      orbit_pend  <= 1'b0;
      sync_frame  <= 1'b0;
      load_strobe <= 1'b0;
      idle_cnt    <= '0;
      DATA32_out  <= {NLANES{IDLE_WORD}};
      for (int k = 0; k < NLANES; k++) staging[k] <= IDLE_WORD;
    end else begin
      cnt         <= boundary ? '0 : cnt + 1'b1;
      load_strobe <= boundary;
      // A new Orbit on the clearing cycle wins, so it is not lost.
      if (Orbit)                          orbit_pend <= 1'b1;
      else if (cnt == '0 && sync_frame)   orbit_pend <= 1'b0;
      if (boundary) begin
        DATA32_out <= frame_result;
        sync_frame <= (mode_nxt == MODE_DATA) && orbit_pend;
        if (mode_q == MODE_ALIGN && align_cnt != AW'(ALIGN_FRAMES))
          align_cnt <= align_cnt + 1'b1;
      end
      if (data_fill) begin
        for (int k = 0; k < NLANES; k++)
          if (cnt == CNT_BITS'(k)) staging[k] <= lane_word;
        if (fifo_empty && idle_cnt != 16'hFFFF) idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule
